fun_param: RTL and testbench

FUN_PARAM -- requirements
Module: fun_param

---
 rtl/fun_pkg.sv | 16 +
 rtl/fun_shift_add_mul.sv | 53 +++++
 rtl/fun_param.sv | 167 ++++++++++++++++
 tb/tb_fun_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fun_pkg.sv
// fun_pkg: shared FSM state type and iteration-count helper for fun_param.
// Shared by the root engine and by the multiplier sizing.
package fun_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROOT = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Root digits (and multiply steps): ceil(w/3) for cbrt, ceil(w/2) for sqrt.
    function automatic int fun_n(input int width, input logic sq);
        return sq ? (width + 1) / 2 : (width + 2) / 3;
    endfunction

endpackage

// File: rtl/fun_shift_add_mul.sv
// fun_shift_add_mul: iterative LSB-first shift-add multiplier.
// load captures operands and step count; done flags the final step.
module fun_shift_add_mul
    import fun_pkg::*;
#(
    parameter int AW = 8,
    parameter int BW = 4,
    parameter int PW = 12,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [CW-1:0] n,
    output logic          done,
    output logic [PW-1:0] sum
);

    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [BW-1:0] mplier;
    logic [CW-1:0] cnt;

    // Partial product after the current step; final product on the done step.
    always_comb begin
        sum  = acc + (mplier[0] ? mcand : '0);
        done = step && (cnt == CW'(1));
    end

    // Accumulate one multiplier bit per step, shifting operands apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= PW'(a);
            mplier <= b;
            cnt    <= n;
        end else if (step && cnt != '0) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/fun_param.sv
// fun_param: result = a * floor(cbrt(b)) or a * floor(sqrt(b)), fixed latency 2*N.
// Define FUN_PARAM_SQRT_EN to honour mode_i and build the square-root datapath.
module fun_param
    import fun_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int RES_W = WIDTH + (WIDTH + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [RES_W-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int NC = fun_n(WIDTH, 1'b0);
`ifdef FUN_PARAM_SQRT_EN
    localparam int NS  = fun_n(WIDTH, 1'b1);
    localparam int RTW = NS;
`else
    localparam int RTW = NC;
`endif
    localparam int RADW = 3 * RTW;
    localparam int RW   = 3 * RTW + 3;
    localparam int CW   = $clog2(RTW + 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [RADW-1:0]  rad;
    logic [RW-1:0]    rem;
    logic [RTW-1:0]   root;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    n_cur;

    logic [RW-1:0]    r2;
    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    d;
    logic [RW-1:0]    rem_nx;
    logic [RTW-1:0]   root_nx;
    logic [RADW-1:0]  rad_nx;
    logic [RADW-1:0]  rad_cb;

    logic             mul_load;
    logic             mul_step;
    logic             mul_done;
    logic [RES_W-1:0] mul_sum;

`ifdef FUN_PARAM_SQRT_EN
    logic             mode_r;
    logic [RADW-1:0]  rad_sq;
`else
    logic             unused_mode;
    assign unused_mode = mode_i;
`endif

    assign busy   = (state != ST_IDLE);
    assign rad_cb = RADW'(b_i) << (RADW - 3 * NC);

    // One root digit per cycle: bring down digit bits, try root bit 1.
    always_comb begin
        r2      = RW'({root, 1'b0});
        rem_sh  = RW'({rem, rad[RADW-1 -: 3]});
        d       = RW'(3) * r2 * (r2 + RW'(1)) + RW'(1);
        rad_nx  = rad << 3;
        n_cur   = CW'(NC);
`ifdef FUN_PARAM_SQRT_EN
        rad_sq  = RADW'(b_i) << (RADW - 2 * NS);
        if (mode_r) begin
            rem_sh = RW'({rem, rad[RADW-1 -: 2]});
            d      = {r2[RW-2:0], 1'b0} + RW'(1);
            rad_nx = rad << 2;
            n_cur  = CW'(NS);
        end
`endif
        if (rem_sh >= d) begin
            rem_nx  = rem_sh - d;
            root_nx = {root[RTW-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh;
            root_nx = {root[RTW-2:0], 1'b0};
        end
    end

    assign mul_load = (state == ST_ROOT) && (cnt == CW'(1));
    assign mul_step = (state == ST_MUL);

    fun_shift_add_mul #(
        .AW (WIDTH),
        .BW (RTW),
        .PW (RES_W),
        .CW (CW)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .step (mul_step),
        .a    (a_r),
        .b    (root_nx),
        .n    (n_cur),
        .done (mul_done),
        .sum  (mul_sum)
    );

    // Sequencer: latch operands, run root digits, then wait for the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
`ifdef FUN_PARAM_SQRT_EN
            mode_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a_i;
                        rem   <= '0;
                        root  <= '0;
                        state <= ST_ROOT;
`ifdef FUN_PARAM_SQRT_EN
                        mode_r <= mode_i;
                        if (mode_i) begin
                            rad <= rad_sq;
                            cnt <= CW'(NS);
                        end else begin
                            rad <= rad_cb;
                            cnt <= CW'(NC);
                        end
`else
                        rad <= rad_cb;
                        cnt <= CW'(NC);
`endif
                    end
                end
                ST_ROOT: begin
                    rem  <= rem_nx;
                    root <= root_nx;
                    rad  <= rad_nx;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result <= mul_sum;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fun_param.sv
// tb_fun_param: WIDTH=8 and WIDTH=16 instances against a transaction-level model.
// Define FUN_PARAM_SQRT_EN to exercise the square-root mode expectations.
module tb_fun_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, m8, s16, m16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [11:0] res8;
    logic [23:0] res16;
    logic        busy8, done8, busy16, done16;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    int     m_left [2];
    bit     m_done [2];
    longint m_res  [2];
    longint m_pend [2];

    fun_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .mode_i(m8),
        .a_i(a8), .b_i(b8), .result(res8), .busy(busy8), .done(done8)
    );

    fun_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .mode_i(m16),
        .a_i(a16), .b_i(b16), .result(res16), .busy(busy16), .done(done16)
    );

    function automatic bit eff_mode(bit m);
`ifdef FUN_PARAM_SQRT_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    function automatic int n_of(int w, bit m);
        return m ? (w + 1) / 2 : (w + 2) / 3;
    endfunction

    function automatic longint iroot(longint b, bit m);
        longint r = 0;
        if (m) begin
            while ((r + 1) * (r + 1) <= b) r++;
        end else begin
            while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
        end
        return r;
    endfunction

    function automatic bit busy_of(int k);
        return k != 0 ? busy16 : busy8;
    endfunction

    function automatic bit done_of(int k);
        return k != 0 ? done16 : done8;
    endfunction

    function automatic longint res_of(int k);
        return k != 0 ? longint'(res16) : longint'(res8);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(int k, bit s, bit m, int a, int b);
        if (k != 0) begin
            s16 = s; m16 = m; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            s8 = s; m8 = m; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: fixed busy window, product posted at its end.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit s, m;
            longint a, b;
            int w;
            s = k != 0 ? s16 : s8;
            m = eff_mode(k != 0 ? m16 : m8);
            a = k != 0 ? longint'(a16) : longint'(a8);
            b = k != 0 ? longint'(b16) : longint'(b8);
            w = k != 0 ? 16 : 8;
            if (rst) begin
                m_left[k] = 0;
                m_done[k] = 0;
                m_res[k]  = 0;
            end else begin
                m_done[k] = 0;
                if (m_left[k] > 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_res[k]  = m_pend[k];
                        m_done[k] = 1;
                    end
                end else if (s) begin
                    m_left[k] = 2 * n_of(w, m);
                    m_pend[k] = a * iroot(b, m);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk(k != 0 ? "busy16" : "busy8", longint'(busy_of(k)), longint'(m_left[k] > 0));
                chk(k != 0 ? "done16" : "done8", longint'(done_of(k)), longint'(m_done[k]));
                chk(k != 0 ? "res16" : "res8", res_of(k), m_res[k]);
            end
        end
    end

    task automatic op(int k, bit m, int a, int b, longint exp_res, int exp_busy, int glitch);
        int nb = 0;
        int nd = 0;
        bit seen = 0;
        @(negedge clk);
        drive(k, 1, m, a, b);
        @(negedge clk);
        drive(k, 0, m, a, b);
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done_of(k)) begin
                seen = 1;
                nd = 1;
            end else begin
                if (busy_of(k)) nb++;
                if (i == glitch) drive(k, 1, m, 1, 1);
                else if (i == glitch + 1) drive(k, 0, m, 1, 1);
                @(negedge clk);
            end
        end
        chk("op_done_seen", longint'(seen), 1);
        chk("op_result", res_of(k), exp_res);
        chk("op_busy_cycles", nb, exp_busy);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_of(k)) nd++;
        end
        chk("op_done_pulses", nd, 1);
    endtask

    task automatic wait_done(int k, output int t, output bit ok);
        ok = 0;
        t  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_of(k)) begin
                ok = 1;
                t  = cyc;
                return;
            end
        end
    endtask

    initial begin
        int t1, t2;
        bit ok1, ok2;
        rst = 1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_res8", longint'(res8), 0);
        chk("reset_busy8", longint'(busy8), 0);
        chk("reset_res16", longint'(res16), 0);
        rst = 0;

        op(0, 0, 5, 27, 15, 6, -5);
        op(0, 0, 3, 64, 12, 6, -5);
        op(0, 0, 9, 125, 45, 6, -5);
        op(0, 0, 255, 200, 1275, 6, -5);
        op(0, 0, 255, 255, 1530, 6, -5);
        op(0, 0, 7, 0, 0, 6, -5);
        op(0, 0, 0, 200, 0, 6, -5);
`ifdef FUN_PARAM_SQRT_EN
        op(0, 1, 7, 200, 98, 8, -5);
`else
        op(0, 1, 7, 200, 35, 6, -5);
`endif
        op(0, 0, 5, 27, 15, 6, 1);
        op(1, 0, 1000, 65535, 40000, 12, -5);

        // Reset during the third busy cycle, with a competing start.
        @(negedge clk);
        drive(0, 1, 0, 5, 27);
        @(negedge clk);
        drive(0, 0, 0, 5, 27);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        drive(0, 1, 0, 9, 125);
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 9, 125);
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_result", longint'(res8), 0);
        chk("rst_done", longint'(done8), 0);
        @(negedge clk);
        chk("rst_no_done", longint'(done8), 0);
        op(0, 0, 5, 27, 15, 6, -5);

        // Start held high: back-to-back operations.
        @(negedge clk);
        drive(1, 1, 0, 1000, 65535);
        wait_done(1, t1, ok1);
        chk("b2b_first_done", longint'(ok1), 1);
        chk("b2b_first_res", longint'(res16), 40000);
        wait_done(1, t2, ok2);
        drive(1, 0, 0, 0, 0);
        chk("b2b_second_done", longint'(ok2), 1);
        chk("b2b_second_res", longint'(res16), 40000);
        chk("b2b_spacing", t2 - t1, 13);

        // Random traffic on both instances, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            drive(0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            drive(1, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        end
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
